// File: rtl/exec_pkg.sv
// exec_pkg: shared ALU op codes, opcodes, branch funct3 values and instruction types for the execute stage.
package exec_pkg;
  typedef enum logic [2:0] {
    ALU_ARITH  = 3'b000,
    ALU_BRANCH = 3'b001,
    ALU_ADD    = 3'b010,
    ALU_LUI    = 3'b011,
    ALU_AUIPC  = 3'b100,
    ALU_JUMP   = 3'b101
  } alu_op_e;
  typedef enum logic [2:0] {IT_R, IT_I, IT_S, IT_B, IT_U, IT_J} instr_type_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  // EXMEM beats MEMWB; register x0 never forwards
  function automatic logic [31:0] fwd(
    input logic [4:0]  src,
    input logic [31:0] rf,
    input logic        ex_we,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_d,
    input logic        mw_we,
    input logic [4:0]  mw_rd,
    input logic [31:0] mw_d
  );
    return (ex_we && ex_rd != 5'd0 && ex_rd == src) ? ex_d :
           (mw_we && mw_rd != 5'd0 && mw_rd == src) ? mw_d : rf;
  endfunction
endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational ALU and branch comparator; EXEC_MUL_EN enables MUL/MULH/MULHU.
module exec_alu
  import exec_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [2:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [6:0]  opcode,
  output logic [31:0] result,
  output logic        taken
);
  logic [31:0] arith, sra, mul;
  logic eq, lt, ltu, cond, muldiv;
  assign sra    = $signed(a) >>> b[4:0];
  assign eq     = a == b;
  assign lt     = $signed(a) < $signed(b);
  assign ltu    = a < b;
  assign muldiv = opcode == OP_R && funct7 == F7_MULDIV;
`ifdef EXEC_MUL_EN
  logic [63:0] mul_ss, mul_uu;
  assign mul_ss = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign mul_uu = {32'd0, a} * {32'd0, b};
  always_comb begin
    case (funct3)
      3'b000:  mul = mul_uu[31:0];
      3'b001:  mul = mul_ss[63:32];
      3'b011:  mul = mul_uu[63:32];
      default: mul = '0;
    endcase
  end
`else
  assign mul = '0;
`endif
  always_comb begin
    case (funct3)
      3'b000:  arith = (funct7[5] && opcode == OP_R) ? a - b : a + b;
      3'b001:  arith = a << b[4:0];
      3'b010:  arith = {31'd0, lt};
      3'b011:  arith = {31'd0, ltu};
      3'b100:  arith = a ^ b;
      3'b101:  arith = funct7[5] ? sra : a >> b[4:0];
      3'b110:  arith = a | b;
      default: arith = a & b;
    endcase
    if (muldiv) arith = mul;
  end
  always_comb begin
    case (funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = !lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = !ltu;
      default: cond = 1'b0;
    endcase
  end
  always_comb begin
    result = '0;
    taken  = 1'b0;
    case (alu_op)
      ALU_ARITH:  result = arith;
      ALU_BRANCH: taken = cond;
      ALU_ADD:    result = a + b;
      ALU_LUI:    result = imm;
      ALU_AUIPC:  result = pc + imm;
      ALU_JUMP: begin
        result = pc + 32'd4;
        taken  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/stage_execute.sv
// stage_execute: EX stage with operand forwarding and the EX/MEM pipeline register (EXEC_MUL_EN adds multiply).
module stage_execute
  import exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_instruction,
  input  logic [31:0] in_PC,
  input  logic [31:0] in_data_rs1,
  input  logic [31:0] in_data_rs2,
  input  logic [31:0] in_immediate,
  input  logic        in_alu_src,
  input  logic [2:0]  in_alu_op,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_EXMEM_rd,
  input  logic [4:0]  in_MEMWB_rd,
  input  logic        in_EXMEM_write_enable,
  input  logic        in_MEMWB_write_enable,
  input  logic [31:0] in_EXMEM_alu_out,
  input  logic [31:0] in_MEMWB_out_data,
  input  logic [6:0]  in_funct7,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_instr_type,
  input  logic        in_mem_write,
  input  logic        in_mem_read,
  input  logic        in_branch_inst,
  input  logic        in_mem_to_reg,
  input  logic        in_write_enable,
  output logic [31:0] out_alu_out,
  output logic [31:0] out_PC,
  output logic        out_branch_taken,
  output logic        out_flush,
  output logic [4:0]  out_rd,
  output logic [31:0] out_mem_in_data,
  output logic        out_mem_write,
  output logic        out_mem_read,
  output logic        out_branch_inst,
  output logic        out_mem_to_reg,
  output logic        out_write_enable
);
  logic [31:0] rs1_val, rs2_val, op_b, result, target;
  logic alu_taken, taken, unused;
  assign unused  = ^{in_instr_type, in_instruction[31:12], in_instruction[6:0]};
  assign rs1_val = fwd(in_rs1, in_data_rs1, in_EXMEM_write_enable, in_EXMEM_rd, in_EXMEM_alu_out,
                       in_MEMWB_write_enable, in_MEMWB_rd, in_MEMWB_out_data);
  assign rs2_val = fwd(in_rs2, in_data_rs2, in_EXMEM_write_enable, in_EXMEM_rd, in_EXMEM_alu_out,
                       in_MEMWB_write_enable, in_MEMWB_rd, in_MEMWB_out_data);
  assign op_b    = in_alu_src ? in_immediate : rs2_val;
  exec_alu u_alu (
    .a      (rs1_val),
    .b      (op_b),
    .pc     (in_PC),
    .imm    (in_immediate),
    .alu_op (in_alu_op),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .opcode (in_opcode),
    .result (result),
    .taken  (alu_taken)
  );
  // conditional branches only redirect when decode marked the instruction as a branch
  assign taken  = in_alu_op == ALU_BRANCH ? alu_taken & in_branch_inst : alu_taken;
  assign target = (in_alu_op == ALU_JUMP && in_opcode == OP_JALR) ? (rs1_val + in_immediate) & ~32'd1
                                                                  : in_PC + in_immediate;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_alu_out      <= '0;
      out_PC           <= '0;
      out_branch_taken <= 1'b0;
      out_flush        <= 1'b0;
      out_rd           <= '0;
      out_mem_in_data  <= '0;
      out_mem_write    <= 1'b0;
      out_mem_read     <= 1'b0;
      out_branch_inst  <= 1'b0;
      out_mem_to_reg   <= 1'b0;
      out_write_enable <= 1'b0;
    end else begin
      out_alu_out      <= result;
      out_PC           <= taken ? target : '0;
      out_branch_taken <= taken;
      out_flush        <= taken;
      out_rd           <= in_instruction[11:7];
      out_mem_in_data  <= rs2_val;
      out_mem_write    <= in_mem_write;
      out_mem_read     <= in_mem_read;
      out_branch_inst  <= in_branch_inst;
      out_mem_to_reg   <= in_mem_to_reg;
      out_write_enable <= in_write_enable;
    end
  end
endmodule

// File: tb/tb_stage_execute.sv
// tb_stage_execute: scoreboard bench for stage_execute; expectations come from an independent reference model.
module tb_stage_execute;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] in_instruction, in_PC, in_data_rs1, in_data_rs2, in_immediate;
  logic        in_alu_src;
  logic [2:0]  in_alu_op;
  logic [4:0]  in_rs1, in_rs2, in_EXMEM_rd, in_MEMWB_rd;
  logic        in_EXMEM_write_enable, in_MEMWB_write_enable;
  logic [31:0] in_EXMEM_alu_out, in_MEMWB_out_data;
  logic [6:0]  in_funct7, in_opcode;
  logic [2:0]  in_funct3, in_instr_type;
  logic        in_mem_write, in_mem_read, in_branch_inst, in_mem_to_reg, in_write_enable;
  logic [31:0] out_alu_out, out_PC, out_mem_in_data;
  logic        out_branch_taken, out_flush;
  logic [4:0]  out_rd;
  logic        out_mem_write, out_mem_read, out_branch_inst, out_mem_to_reg, out_write_enable;

  stage_execute dut (
    .clk(clk), .reset(reset), .in_instruction(in_instruction), .in_PC(in_PC),
    .in_data_rs1(in_data_rs1), .in_data_rs2(in_data_rs2), .in_immediate(in_immediate),
    .in_alu_src(in_alu_src), .in_alu_op(in_alu_op), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_EXMEM_rd(in_EXMEM_rd), .in_MEMWB_rd(in_MEMWB_rd),
    .in_EXMEM_write_enable(in_EXMEM_write_enable), .in_MEMWB_write_enable(in_MEMWB_write_enable),
    .in_EXMEM_alu_out(in_EXMEM_alu_out), .in_MEMWB_out_data(in_MEMWB_out_data),
    .in_funct7(in_funct7), .in_funct3(in_funct3), .in_opcode(in_opcode), .in_instr_type(in_instr_type),
    .in_mem_write(in_mem_write), .in_mem_read(in_mem_read), .in_branch_inst(in_branch_inst),
    .in_mem_to_reg(in_mem_to_reg), .in_write_enable(in_write_enable),
    .out_alu_out(out_alu_out), .out_PC(out_PC), .out_branch_taken(out_branch_taken),
    .out_flush(out_flush), .out_rd(out_rd), .out_mem_in_data(out_mem_in_data),
    .out_mem_write(out_mem_write), .out_mem_read(out_mem_read), .out_branch_inst(out_branch_inst),
    .out_mem_to_reg(out_mem_to_reg), .out_write_enable(out_write_enable)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] pc;
    logic        tk;
    logic [4:0]  rd;
    logic [31:0] md;
    logic [4:0]  ctl;
  } exp_t;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd_m(input logic [4:0] s, input logic [31:0] rf);
    if (in_EXMEM_write_enable && in_EXMEM_rd != 0 && in_EXMEM_rd == s) return in_EXMEM_alu_out;
    if (in_MEMWB_write_enable && in_MEMWB_rd != 0 && in_MEMWB_rd == s) return in_MEMWB_out_data;
    return rf;
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic [31:0] a, r2, b, t;
    longint sa, sb2;
    longint unsigned ua, ub;
    int si;
    logic c;
    a  = fwd_m(in_rs1, in_data_rs1);
    r2 = fwd_m(in_rs2, in_data_rs2);
    b  = in_alu_src ? in_immediate : r2;
    e = '0;
    c = 1'b0;
    t = in_PC + in_immediate;
    e.rd  = in_instruction[11:7];
    e.md  = r2;
    e.ctl = {in_mem_write, in_mem_read, in_branch_inst, in_mem_to_reg, in_write_enable};
    sa = $signed(a); sb2 = $signed(b); ua = a; ub = b;
    case (in_alu_op)
      3'd0:
        if (in_opcode == 7'h33 && in_funct7 == 7'h01) begin
`ifdef EXEC_MUL_EN
          if (in_funct3 == 3'd0) e.alu = a * b;
          else if (in_funct3 == 3'd1) e.alu = 32'((sa * sb2) >> 32);
          else if (in_funct3 == 3'd3) e.alu = 32'((ua * ub) >> 32);
`endif
        end else
          case (in_funct3)
            3'd0: e.alu = (in_funct7[5] && in_opcode == 7'h33) ? a - b : a + b;
            3'd1: e.alu = a << b[4:0];
            3'd2: e.alu = {31'd0, sa < sb2};
            3'd3: e.alu = {31'd0, ua < ub};
            3'd4: e.alu = a ^ b;
            3'd5: if (in_funct7[5]) begin si = a; si = si >>> b[4:0]; e.alu = si; end
                  else e.alu = a >> b[4:0];
            3'd6: e.alu = a | b;
            default: e.alu = a & b;
          endcase
      3'd1: begin
        case (in_funct3)
          3'd0: c = a == b;
          3'd1: c = a != b;
          3'd4: c = sa < sb2;
          3'd5: c = sa >= sb2;
          3'd6: c = ua < ub;
          3'd7: c = ua >= ub;
          default: c = 1'b0;
        endcase
        e.tk = c & in_branch_inst;
      end
      3'd2: e.alu = a + b;
      3'd3: e.alu = in_immediate;
      3'd4: e.alu = in_PC + in_immediate;
      3'd5: begin
        e.alu = in_PC + 32'd4;
        e.tk  = 1'b1;
        if (in_opcode == 7'h67) t = (a + in_immediate) & 32'hFFFF_FFFE;
      end
      default: ;
    endcase
    e.pc = e.tk ? t : 32'd0;
    return e;
  endfunction

  task automatic set_op(input logic [2:0] op, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic src, input logic [31:0] pc);
    in_alu_op = op; in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
    in_data_rs1 = v1; in_data_rs2 = v2; in_immediate = imm; in_alu_src = src; in_PC = pc;
    in_rs1 = 5'd1; in_rs2 = 5'd2;
    in_EXMEM_rd = 5'd0; in_MEMWB_rd = 5'd0; in_EXMEM_write_enable = 1'b0; in_MEMWB_write_enable = 1'b0;
    in_EXMEM_alu_out = $urandom; in_MEMWB_out_data = $urandom;
    in_branch_inst = op == 3'd1;
    in_instruction = $urandom; in_instr_type = 3'($urandom_range(0, 5));
    {in_mem_write, in_mem_read, in_mem_to_reg, in_write_enable} = 4'($urandom);
  endtask

  task automatic send();
    exp_t e;
    sb.push_back(model());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("alu_out", out_alu_out, e.alu);
    check("pc", out_PC, e.pc);
    check("taken", {31'd0, out_branch_taken}, {31'd0, e.tk});
    check("flush", {31'd0, out_flush}, {31'd0, e.tk});
    check("rd", {27'd0, out_rd}, {27'd0, e.rd});
    check("mem_in_data", out_mem_in_data, e.md);
    check("ctl", {27'd0, out_mem_write, out_mem_read, out_branch_inst, out_mem_to_reg, out_write_enable},
          {27'd0, e.ctl});
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_alu"}, out_alu_out, 32'd0);
    check({tag, "_pc"}, out_PC, 32'd0);
    check({tag, "_md"}, out_mem_in_data, 32'd0);
    check({tag, "_misc"}, {16'd0, out_rd, out_branch_taken, out_flush, out_mem_write, out_mem_read,
          out_branch_inst, out_mem_to_reg, out_write_enable, 4'd0}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] opcs [5];
    logic [6:0] f7s [4];
    opcs = '{7'h33, 7'h13, 7'h67, 7'h6f, 7'h63};
    f7s  = '{7'h00, 7'h20, 7'h01, 7'h7f};
    set_op(3'd0, 7'h33, 3'd0, 7'd0, 32'd5, 32'd3, 32'd0, 1'b0, 32'd0);
    #1 reset = 1'b0;
    #2 check_zero("reset_async");
    @(posedge clk); #1 check_zero("reset_held");
    @(negedge clk) reset = 1'b1;
    // first edge after release captures the inputs present there
    send(); check("add_r", out_alu_out, 32'd8);
    set_op(3'd0, 7'h13, 3'd0, 7'h20, 32'd5, 32'd99, 32'd3, 1'b1, 32'd0);
    send(); check("addi", out_alu_out, 32'd8);
    set_op(3'd0, 7'h33, 3'd0, 7'h20, 32'd5, 32'd3, 32'd0, 1'b0, 32'd0);
    send(); check("sub", out_alu_out, 32'd2);
    set_op(3'd0, 7'h33, 3'd5, 7'h20, 32'h8000_0000, 32'h24, 32'd0, 1'b0, 32'd0);
    send(); check("sra", out_alu_out, 32'hF800_0000);
    set_op(3'd1, 7'h63, 3'd0, 7'd0, 32'd5, 32'd5, 32'd8, 1'b0, 32'h100);
    send(); check("beq_eq", {31'd0, out_branch_taken}, 32'd1); check("beq_flush", {31'd0, out_flush}, 32'd1);
    set_op(3'd1, 7'h63, 3'd0, 7'd0, 32'd5, 32'd3, 32'd8, 1'b0, 32'h100);
    send(); check("beq_ne", {31'd0, out_branch_taken}, 32'd0); check("beq_ne_pc", out_PC, 32'd0);
    set_op(3'd1, 7'h63, 3'd1, 7'd0, 32'd5, 32'd5, 32'd8, 1'b0, 32'h100);
    send(); check("bne_eq", {31'd0, out_branch_taken}, 32'd0);
    set_op(3'd1, 7'h63, 3'd1, 7'd0, 32'd5, 32'd3, 32'd8, 1'b0, 32'h100);
    in_branch_inst = 1'b0;
    send(); check("bne_nobranch", {31'd0, out_branch_taken}, 32'd0);
    set_op(3'd5, 7'h67, 3'd0, 7'd0, 32'h1001, 32'd0, 32'd4, 1'b1, 32'h200);
    send(); check("jalr_pc", out_PC, 32'h1004); check("jalr_link", out_alu_out, 32'h204);
    set_op(3'd6, 7'h33, 3'd0, 7'd0, 32'd5, 32'd3, 32'd0, 1'b0, 32'd0);
    send(); check("op110", out_alu_out, 32'd0);
    set_op(3'd2, 7'h33, 3'd0, 7'd0, 32'd7, 32'd1, 32'd0, 1'b0, 32'd0);
    in_rs1 = 5'd2; in_rs2 = 5'd4;
    in_EXMEM_rd = 5'd2; in_EXMEM_write_enable = 1'b1; in_EXMEM_alu_out = 32'h20;
    in_MEMWB_rd = 5'd2; in_MEMWB_write_enable = 1'b1; in_MEMWB_out_data = 32'h30;
    send(); check("fwd_prio", out_alu_out, 32'h21);
    set_op(3'd1, 7'h63, 3'd1, 7'd0, 32'd5, 32'd3, 32'd8, 1'b0, 32'h100);
    send(); check("bne_taken", {31'd0, out_branch_taken}, 32'd1); check("bne_pc", out_PC, 32'h108);
    // reset between edges, then an instruction in flight is discarded
    #2 reset = 1'b0;
    #1 check_zero("reset_mid");
    set_op(3'd2, 7'h33, 3'd0, 7'd0, 32'd9, 32'd9, 32'd0, 1'b0, 32'd0);
    sb.push_back(model());
    @(posedge clk); #1 check_zero("reset_discard");
    sb.delete();
    @(negedge clk) reset = 1'b1;
    send(); check("after_reset", out_alu_out, 32'd18);
    for (int i = 0; i < 80; i++) begin
      set_op(3'($urandom_range(0, 7)), opcs[$urandom_range(0, 4)], 3'($urandom), f7s[$urandom_range(0, 3)],
             ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
             $urandom, $urandom, 1'($urandom), $urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 3) == 0) in_data_rs2 = in_data_rs1;
      in_rs1 = 5'($urandom_range(0, 3)); in_rs2 = 5'($urandom_range(0, 3));
      in_EXMEM_rd = 5'($urandom_range(0, 3)); in_MEMWB_rd = 5'($urandom_range(0, 3));
      in_EXMEM_write_enable = 1'($urandom); in_MEMWB_write_enable = 1'($urandom);
      in_branch_inst = 1'($urandom);
      send();
    end
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stage_execute.md
STAGE_EXECUTE -- requirements
Module: stage_execute

Interface
REQ-001 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 Port reset, input, 1 bit: asynchronous, active-low reset; 0 = reset asserted.
REQ-003 Port in_instruction, input, 32 bits: instruction word; the destination register is bits [11:7].
REQ-004 Ports in_PC, in_data_rs1, in_data_rs2 and in_immediate, inputs, 32 bits each: PC, register-file operands and sign-extended immediate.
REQ-005 Port in_alu_src, input, 1 bit: 1 = operand B is in_immediate, 0 = operand B is forwarded rs2.
REQ-006 Port in_alu_op, input, 3 bits: ALU class, encoded in the shared package.
REQ-007 Ports in_rs1 and in_rs2, inputs, 5 bits each: source register indices.
REQ-008 Ports in_EXMEM_rd and in_MEMWB_rd, inputs, 5 bits each: destination registers of the downstream stages.
REQ-009 Ports in_EXMEM_write_enable and in_MEMWB_write_enable, inputs, 1 bit each: downstream write enables.
REQ-010 Ports in_EXMEM_alu_out and in_MEMWB_out_data, inputs, 32 bits each: forwarding data.
REQ-011 Ports in_funct7 (7 bits), in_funct3 (3 bits), in_opcode (7 bits) and in_instr_type (3 bits), inputs: decode fields.
REQ-012 Ports in_mem_write, in_mem_read, in_branch_inst, in_mem_to_reg and in_write_enable, inputs, 1 bit each: control signals passed through to the next stage.
REQ-013 Outputs out_alu_out (32 bits), out_PC (32 bits), out_branch_taken (1 bit) and out_flush (1 bit).
REQ-014 Outputs out_rd (5 bits) and out_mem_in_data (32 bits): registered destination register and forwarded rs2 data.
REQ-015 Outputs out_mem_write, out_mem_read, out_branch_inst, out_mem_to_reg and out_write_enable, 1 bit each: registered copies of the matching inputs.

Function
REQ-016 Forwarding, per source register: if the EXMEM write enable is 1, EXMEM rd is nonzero and EXMEM rd equals the source index, use in_EXMEM_alu_out; otherwise, under the same test on MEMWB, use in_MEMWB_out_data; otherwise use the register-file data.
REQ-017 Forwarding from EXMEM SHALL take priority over forwarding from MEMWB.
REQ-018 ALU_ARITH (000): the operation is selected by funct3 and funct7 -- ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
REQ-019 ALU_ARITH: SUB and SRA are selected by funct7[5]; the SUB form applies to the R-type opcode only.
REQ-020 Shift amounts SHALL use operand B bits [4:0].
REQ-021 ALU_BRANCH (001): taken = 1 when the condition holds -- funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; branch target = PC + immediate.
REQ-022 ALU_ADD (010) = operand A + operand B; ALU_LUI (011) = immediate.
REQ-023 ALU_AUIPC (100) = PC + immediate.
REQ-024 ALU_JUMP (101): out_alu_out = PC + 4 and taken = 1; target = PC + immediate for JAL, (rs1 + immediate) & ~1 for JALR.
REQ-025 Codes 110 and 111 SHALL give out_alu_out = 0 and taken = 0.
REQ-026 Arithmetic is 32-bit and wraps modulo 2^32; carries are discarded.
REQ-027 Latency is 1 cycle: every output is registered at the rising clock edge, forming the EX/MEM register.
REQ-028 out_flush = out_branch_taken; out_PC holds the target and is 0 when not taken.
REQ-029 A branch with in_branch_inst = 0 SHALL NOT assert taken.
REQ-030 out_mem_in_data = forwarded rs2, regardless of in_alu_src.

Reset
REQ-031 While reset = 0, all outputs are 0 immediately, without waiting for a clock edge.
REQ-032 Reset asserted mid-operation discards the instruction in flight.
REQ-033 On the first rising edge after reset deasserts, the outputs reflect the inputs present at that edge.

Configuration
REQ-034 With EXEC_MUL_EN defined: R-type with funct7 0000001 computes MUL (funct3 000, low 32 bits), MULH (001, signed x signed) and MULHU (011, unsigned x unsigned).
REQ-035 Without EXEC_MUL_EN: those encodings give out_alu_out = 0.

Structure
REQ-036 Package exec_pkg SHALL hold the alu_op enum, the opcode constants, the branch funct3 constants and the instr_type enum (R, I, S, B, U, J).
REQ-037 One sub-module, exec_alu, SHALL be combinational: operands, alu_op, funct3, funct7 and opcode in; result and taken out.

Verification
REQ-038 rs1 = 5, rs2 = 3, alu_op 000, opcode 0110011, funct3 000, funct7 0 -> out_alu_out = 8 after one clock edge.
REQ-039 rs1 = 5, immediate = 3, alu_src = 1, opcode 0010011, funct3 000 -> out_alu_out = 8.
REQ-040 BEQ (alu_op 001, branch_inst 1), 5 vs 5 -> taken = 1 and flush = 1; 5 vs 3 -> taken = 0.
REQ-041 BNE, 5 vs 3 -> taken = 1; 5 vs 5 -> taken = 0; PC = 0x100, immediate = 8, taken -> out_PC = 0x108.
REQ-042 rs1 = 2, EXMEM rd = 2, EXMEM write enable = 1, EXMEM data = 0x20, MEMWB rd = 2 with data 0x30 -> the EXMEM value wins, so ADD with rs2 = 1 gives 0x21.
REQ-043 Drive reset = 0 asynchronously between clock edges -> all outputs are 0 before the next edge.
